// File: rtl/com_pkg.sv
// Shared types and constants for the UART transmit path that drains the CPU
// communication stage.
package com_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/com_fifo.sv
// Circular-buffer byte FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module com_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/com_uart_tx.sv
// Buffers bytes from the CPU communication strobe and sends them as 8N1 UART
// frames; flags bytes lost to a full buffer.
module com_uart_tx
  import com_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        byte_strobe,
  input  logic [7:0]                  byte_data,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        overflow
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      s_q1, s_q2;
  logic                      push_req;
  logic                      pop;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] head;

  tx_state_t                 state_q, state_d;
  logic [BW-1:0]             baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      overflow_q, overflow_d;
  logic                      baud_last;

  // Level strobe -> single push one cycle after its rise.
  assign push_req = s_q1 & ~s_q2;

  com_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .wr_data (byte_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // tx and busy are registered from the next state so they change together.
    busy_d     = (state_d != IDLE);
    overflow_d = overflow_q | (push_req & fifo_full & ~pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q1       <= 1'b0;
      s_q2       <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s_q1       <= byte_strobe;
      s_q2       <= s_q1;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_com_uart_tx.sv
// Bench for com_uart_tx: logs the serial line every cycle and decodes 8N1 frames
// against a queue of expected bytes.
module tb_com_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int LOGN  = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_strobe = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       tx, busy, fifo_full, overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int max_cnt = 0;

  logic line     [LOGN];
  logic busy_log [LOGN];
  int   cnt_log  [LOGN];

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         ok;
  } frame_t;

  frame_t     fr_q[$];
  logic [7:0] exp_q[$];

  com_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_strobe (byte_strobe),
    .byte_data   (byte_data),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Index k holds the outputs as they stand after the k-th rising edge.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      line[cyc]     = tx;
      busy_log[cyc] = busy;
      cnt_log[cyc]  = int'(fifo_count);
    end
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d, input int high, output int c);
    @(negedge clk);
    c           = cyc;
    byte_strobe = 1'b1;
    byte_data   = d;
    repeat (high) @(negedge clk);
    byte_strobe = 1'b0;
  endtask

  // Find every start-bit fall in line[from..to) and read the 10-bit frame.
  task automatic decode(input int from, input int to);
    int     i;
    logic   v;
    frame_t f;
    fr_q.delete();
    i = (from < 1) ? 1 : from;
    while (i < to) begin
      if (line[i] === 1'b0 && line[i-1] === 1'b1) begin
        f.start = i;
        f.ok    = 1'b1;
        f.data  = 8'h00;
        if (i + FRAME > to) f.ok = 1'b0;
        for (int b = 0; b < 10; b++) begin
          v = line[i + CPB*b];
          for (int k = 1; k < CPB; k++)
            if (line[i + CPB*b + k] !== v) f.ok = 1'b0;
          if (b == 0 && v !== 1'b0) f.ok = 1'b0;
          if (b == 9 && v !== 1'b1) f.ok = 1'b0;
          if (b >= 1 && b <= 8) f.data[b-1] = v;
        end
        fr_q.push_back(f);
        i = i + FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_frames(input string tag, input int from, input int to, input bit gap);
    int n;
    decode(from, to);
    chk({tag, "_nframes"}, fr_q.size(), exp_q.size());
    n = (fr_q.size() < exp_q.size()) ? fr_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_data%0d", tag, k), fr_q[k].data, exp_q[k]);
      chk($sformatf("%s_shape%0d", tag, k), fr_q[k].ok, 1);
      if (gap && k > 0)
        chk($sformatf("%s_gap%0d", tag, k), fr_q[k].start - fr_q[k-1].start, FRAME + 1);
    end
  endtask

  initial begin
    int         c, c0, r, n, zeros, fill;
    logic [7:0] d;
    bit         ovf_mdl;

    // Reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_full", fifo_full, 0);
    chk("reset_overflow", overflow, 0);

    // Single byte, strobe high three cycles
    pulse(8'hA5, 3, c);
    wait_cyc(60);
    chk("single_prefall", line[c+2], 1);
    chk("single_fall", line[c+3], 0);
    chk("single_count1", cnt_log[c+2], 1);
    chk("single_busy_rise", busy_log[c+3], 1);
    chk("single_busy_prerise", busy_log[c+2], 0);
    chk("single_busy_last", busy_log[c+3+FRAME-1], 1);
    chk("single_busy_fall", busy_log[c+3+FRAME], 0);
    exp_q = '{8'hA5};
    check_frames("single", c, cyc - 1, 1'b0);
    if (fr_q.size() > 0) chk("single_start", fr_q[0].start, c + 3);

    // Long strobe
    max_cnt = 0;
    pulse(8'h3C, 50, c);
    wait_cyc(60);
    exp_q = '{8'h3C};
    check_frames("long", c, cyc - 1, 1'b0);
    chk("long_maxcount", max_cnt, 1);

    // Burst of five while idle
    for (int i = 0; i < 5; i++) begin
      pulse(8'(i + 1), 1, c);
      if (i == 0) c0 = c;
    end
    wait_cyc(2);
    chk("burst_count", fifo_count, 4);
    chk("burst_full", fifo_full, 1);
    chk("burst_overflow", overflow, 0);
    wait_cyc(5 * (FRAME + 1) + 20);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_frames("burst", c0, cyc - 1, 1'b1);
    if (fr_q.size() > 0) chk("burst_start", fr_q[0].start, c0 + 3);
    chk("burst_overflow_end", overflow, 0);

    // Overflow: five pushes while one frame is on the line
    d = 8'($urandom);
    pulse(d, 1, c0);
    wait_cyc(3);
    exp_q   = '{d};
    fill    = 0;
    ovf_mdl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(8'h10 + 8'(i), 1, c);
      if (fill < DEPTH) begin
        exp_q.push_back(8'h10 + 8'(i));
        fill++;
      end else begin
        ovf_mdl = 1'b1;
      end
    end
    wait_cyc(2);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_flag", overflow, ovf_mdl);
    wait_cyc(6 * (FRAME + 1) + 20);
    check_frames("ovf", c0, cyc - 1, 1'b1);
    chk("ovf_flag_held", overflow, ovf_mdl);
    chk("ovf_drained", fifo_count, 0);

    // Random bursts after a fresh reset
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rand_reset_overflow", overflow, 0);
    for (int rnd = 0; rnd < 3; rnd++) begin
      n = int'($urandom_range(1, 5));
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        pulse(d, 1, c);
        if (i == 0) c0 = c;
        exp_q.push_back(d);
      end
      wait_cyc(n * (FRAME + 1) + 30);
      check_frames($sformatf("rand%0d", rnd), c0, cyc - 1, 1'b1);
    end
    chk("rand_overflow", overflow, 0);

    // Reset during data bit 3 of 0xFF with two bytes buffered
    pulse(8'hFF, 1, c0);
    pulse(8'h11, 1, c);
    pulse(8'h22, 1, c);
    while (cyc < c0 + 20) @(negedge clk);
    chk("mid_count_before", fifo_count, 2);
    chk("mid_busy_before", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_tx", tx, 1);
    chk("mid_busy", busy, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_full", fifo_full, 0);
    wait_cyc(2);
    reset = 1'b0;
    r = cyc;
    wait_cyc(150);
    zeros = 0;
    for (int k = r; k < cyc - 1; k++)
      if (line[k] !== 1'b1) zeros++;
    chk("mid_no_frames", zeros, 0);
    chk("mid_busy_after", busy, 0);
    chk("mid_count_after", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/com_uart_tx.md
# com_uart_tx

Downstream consumer of the CPU communication stage. Takes the byte strobe and 8-bit data that the stage emits on every communication-enabled memory read. Buffers those bytes in a small FIFO and serialises them as 8N1 UART frames to the external interpreter host. Decouples the CPU's burst rate from the serial link rate and flags any lost bytes.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200); minimum legal value 2.
- `FIFO_DEPTH`, default 16: byte entries; power of two, 2..256.
- `clk`  in  1  system clock, same domain as the CPU pipeline.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `byte_strobe`  in  1  communication strobe from the upstream stage. Level signal, may stay high several cycles per byte.
- `byte_data`  in  8  byte from the upstream stage. Valid from one cycle after `byte_strobe` rises.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while a frame is on the line.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- `fifo_full`  out  1  `fifo_count == FIFO_DEPTH`.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Strobe capture:
  - `byte_strobe` is registered twice (`s_q1`, `s_q2`).
  - Push request when `s_q1 & ~s_q2`, i.e. one cycle after the rise. `byte_data` is sampled on that same edge.
  - One push per rising edge, regardless of how long the strobe stays high.
- FIFO: circular buffer with read/write pointers and a count.
  - Push when not full.
  - Push while full and no pop in the same cycle: byte dropped, `overflow` set to 1, held until reset.
  - Simultaneous push and pop at any fill level: both take effect and `fifo_count` is unchanged. A full FIFO therefore accepts the push.
- Transmitter FSM (`IDLE`, `START`, `DATA`, `STOP`):
  - `IDLE`: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud and bit counters, go to `START`.
  - `START`: `tx`=0 for `CLKS_PER_BIT` cycles, then go to `DATA`.
  - `DATA`: `tx`=shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` cycles, then shift right. After bit 7, go to `STOP`.
  - `STOP`: `tx`=1 for `CLKS_PER_BIT` cycles, then return to `IDLE`.
- `busy` = state ≠ `IDLE`.
- The baud counter counts 0..`CLKS_PER_BIT`-1 and wraps. The bit counter is 3 bits, 0..7.
- `tx` is a register output (glitch-free).

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `fifo_full`=0, `overflow`=0, state=`IDLE`, pointers=0, `s_q1`=`s_q2`=0.
- Reset is asynchronous and effective mid-frame: `tx` returns to 1 immediately and buffered bytes are discarded.
- Strobe-to-push latency: the strobe rises at edge N, so the push happens at edge N+1.
- With an empty FIFO and the FSM idle:
  - `fifo_count` becomes 1 at N+1.
  - The pop occurs at N+2; `tx` falls and `busy` rises after edge N+2.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles, from the `tx` fall to the end of the stop bit.
- Back-to-back frames: exactly one idle-high cycle (the `IDLE` pop cycle) between one stop bit and the next start bit.
- Strobe re-rises are detected as long as the strobe stays low for at least one sampled cycle between pulses.

## Structure
- Package `com_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`.
  - `localparam UART_DATA_BITS = 8`.
  - Default `CLKS_PER_BIT`.
- Sub-module `com_fifo`: parameterised synchronous FIFO with push/pop/count/full/empty and async active-high reset, using the same `clk`/`reset` names.
- The top level holds the strobe edge detector, the overflow flag and the transmitter FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset: hold `reset` for 3 cycles, then release → `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0.
- Single byte: strobe high for 3 cycles with `byte_data`=0xA5 → exactly one frame on `tx`: 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles. The falling edge of `tx` is 2 cycles after the strobe rise.
- Long strobe: strobe held high for 50 cycles with data 0x3C → exactly one frame; `fifo_count` never exceeds 1.
- Burst: five pulses (0x01..0x05), each 1 cycle high and 1 cycle low, while idle.
  - The first byte is popped immediately; the remaining four fill the FIFO.
  - Final `overflow`=0.
  - Frames appear in order 01,02,03,04,05 with one idle cycle between frames.
- Overflow: during a frame, push 5 more bytes (0x10..0x14) → `fifo_full`=1, 0x14 dropped, `overflow`=1 and held. Subsequent frames carry 0x10..0x13 only.
- Reset mid-frame: assert `reset` during data bit 3 of 0xFF with 2 bytes buffered → `tx`=1 within the same cycle, `fifo_count`=0, and no further frames after release.
